// File: rtl/yuv_to_rgb_pipe.sv
// yuv_to_rgb_pipe: three-stage fixed-point YCbCr to RGB converter.
// Stage 1 forms the scaled luma and chroma products, stage 2 forms the
// rounded channel sums, and stage 3 scales back and clamps to the output
// range. The whole pipe stalls as one unit under back-pressure. A
// saturating counter records how many delivered pixels had a clamped
// channel.
module yuv_to_rgb_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_FRAC  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [DATA_WIDTH-1:0] cb_in,
    input  logic [DATA_WIDTH-1:0] cr_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] r_out,
    output logic [DATA_WIDTH-1:0] g_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  sat_flag,
    input  logic                  sat_clr,
    output logic [CNT_WIDTH-1:0]  sat_count
);

    localparam int ACC = DATA_WIDTH + COEF_FRAC + 4;

    localparam logic signed [ACC-1:0] KR_CR = ACC'(91881);
    localparam logic signed [ACC-1:0] KG_CB = ACC'(22554);
    localparam logic signed [ACC-1:0] KG_CR = ACC'(46802);
    localparam logic signed [ACC-1:0] KB_CB = ACC'(116130);
    localparam logic signed [ACC-1:0] RND   = ACC'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC-1:0] MAXV  = ACC'((2 ** DATA_WIDTH) - 1);

    // Scale a rounded sum back to integer and clamp it; the top bit of the
    // result flags that clamping happened.
    function automatic logic [DATA_WIDTH:0] clampChannel(input logic signed [ACC-1:0] sum);
        logic signed [ACC-1:0] sh;
        sh = sum >>> COEF_FRAC;
        if (sh[ACC-1]) begin
            return {1'b1, {DATA_WIDTH{1'b0}}};
        end else if (sh > MAXV) begin
            return {1'b1, {DATA_WIDTH{1'b1}}};
        end else begin
            return {1'b0, sh[DATA_WIDTH-1:0]};
        end
    endfunction

    logic                   w_advance;
    logic                   w_outFire;
    logic signed [ACC-1:0]  w_yExt;
    logic signed [ACC-1:0]  w_cbExt;
    logic signed [ACC-1:0]  w_crExt;
    logic [DATA_WIDTH:0]    w_clampR;
    logic [DATA_WIDTH:0]    w_clampG;
    logic [DATA_WIDTH:0]    w_clampB;

    logic                   r_s1Valid;
    logic signed [ACC-1:0]  r_ys;
    logic signed [ACC-1:0]  r_pRcr;
    logic signed [ACC-1:0]  r_pGcb;
    logic signed [ACC-1:0]  r_pGcr;
    logic signed [ACC-1:0]  r_pBcb;

    logic                   r_s2Valid;
    logic signed [ACC-1:0]  r_sR;
    logic signed [ACC-1:0]  r_sG;
    logic signed [ACC-1:0]  r_sB;

    logic                   r_outValid;
    logic [DATA_WIDTH-1:0]  r_rOut;
    logic [DATA_WIDTH-1:0]  r_gOut;
    logic [DATA_WIDTH-1:0]  r_bOut;
    logic                   r_satFlag;
    logic [CNT_WIDTH-1:0]   r_satCount;

    // The pipe moves only when the output slot is empty or being consumed.
    assign w_advance = !r_outValid || out_ready;
    assign w_outFire = r_outValid && out_ready;
    assign in_ready  = w_advance;

    // Luma is unsigned and zero-extended; chroma is two's-complement.
    assign w_yExt  = {{(ACC - DATA_WIDTH){1'b0}}, y_in};
    assign w_cbExt = {{(ACC - DATA_WIDTH){cb_in[DATA_WIDTH-1]}}, cb_in};
    assign w_crExt = {{(ACC - DATA_WIDTH){cr_in[DATA_WIDTH-1]}}, cr_in};

    // Stage 1: scaled luma and the four chroma products.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_ys      <= '0;
            r_pRcr    <= '0;
            r_pGcb    <= '0;
            r_pGcr    <= '0;
            r_pBcb    <= '0;
        end else if (w_advance) begin
            r_s1Valid <= in_valid;
            r_ys      <= w_yExt <<< COEF_FRAC;
            r_pRcr    <= w_crExt * KR_CR;
            r_pGcb    <= w_cbExt * KG_CB;
            r_pGcr    <= w_crExt * KG_CR;
            r_pBcb    <= w_cbExt * KB_CB;
        end
    end

    // Stage 2: channel sums with the half-LSB rounding constant folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_sR      <= '0;
            r_sG      <= '0;
            r_sB      <= '0;
        end else if (w_advance) begin
            r_s2Valid <= r_s1Valid;
            r_sR      <= r_ys + r_pRcr + RND;
            r_sG      <= r_ys - r_pGcb - r_pGcr + RND;
            r_sB      <= r_ys + r_pBcb + RND;
        end
    end

    // Clamp results for the stage-3 register.
    always_comb begin
        w_clampR = clampChannel(r_sR);
        w_clampG = clampChannel(r_sG);
        w_clampB = clampChannel(r_sB);
    end

    // Stage 3: clamped RGB plus the per-pixel saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_rOut     <= '0;
            r_gOut     <= '0;
            r_bOut     <= '0;
            r_satFlag  <= 1'b0;
        end else if (w_advance) begin
            r_outValid <= r_s2Valid;
            r_rOut     <= w_clampR[DATA_WIDTH-1:0];
            r_gOut     <= w_clampG[DATA_WIDTH-1:0];
            r_bOut     <= w_clampB[DATA_WIDTH-1:0];
            r_satFlag  <= w_clampR[DATA_WIDTH] | w_clampG[DATA_WIDTH] | w_clampB[DATA_WIDTH];
        end
    end

    // Count delivered saturated pixels, sticking at all-ones; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_satCount <= '0;
        end else if (sat_clr) begin
            r_satCount <= '0;
        end else if (w_outFire && r_satFlag && (r_satCount != {CNT_WIDTH{1'b1}})) begin
            r_satCount <= r_satCount + CNT_WIDTH'(1);
        end
    end

    assign out_valid = r_outValid;
    assign r_out     = r_rOut;
    assign g_out     = r_gOut;
    assign b_out     = r_bOut;
    assign sat_flag  = r_satFlag;
    assign sat_count = r_satCount;

endmodule

// File: tb/tb_yuv_to_rgb_pipe.sv
// tb_yuv_to_rgb_pipe: directed bench for yuv_to_rgb_pipe with a scoreboard.
// Expected pixels are computed with plain integer arithmetic when a pixel is
// accepted and compared when the DUT hands one over.
module tb_yuv_to_rgb_pipe;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sat;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  y_in;
    logic [7:0]  cb_in;
    logic [7:0]  cr_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  r_out;
    logic [7:0]  g_out;
    logic [7:0]  b_out;
    logic        sat_flag;
    logic        sat_clr;
    logic [15:0] sat_count;

    pix_t expQ[$];
    int   compCount = 0;
    int   errCount  = 0;
    int   expCount  = 0;
    bit   seenReset = 1'b0;
    bit   checkInReady = 1'b0;
    bit   prevStall = 1'b0;
    pix_t heldPix;
    pix_t obsPix;
    pix_t expPix;
    bit   incNext;

    yuv_to_rgb_pipe #(
        .DATA_WIDTH (8),
        .COEF_FRAC  (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .cb_in     (cb_in),
        .cr_in     (cr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Integer reference: floor of the rounded sum, clamped to 0..255.
    function automatic logic [8:0] refChannel(input int v);
        if (v < 0) begin
            return 9'h100;
        end else if ((v / 65536) > 255) begin
            return 9'h1FF;
        end else begin
            return {1'b0, 8'(v / 65536)};
        end
    endfunction

    function automatic pix_t goldenModel(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        int yi;
        int cbi;
        int cri;
        logic [8:0] cR;
        logic [8:0] cG;
        logic [8:0] cB;
        pix_t p;
        yi  = int'(y);
        cbi = int'($signed(cb));
        cri = int'($signed(cr));
        cR  = refChannel(yi * 65536 + cri * 91881 + 32768);
        cG  = refChannel(yi * 65536 - cbi * 22554 - cri * 46802 + 32768);
        cB  = refChannel(yi * 65536 + cbi * 116130 + 32768);
        p.r   = cR[7:0];
        p.g   = cG[7:0];
        p.b   = cB[7:0];
        p.sat = cR[8] | cG[8] | cB[8];
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, note acceptance, push the expected pixel.
    task automatic applyStimulus(input logic v, input logic [7:0] y, input logic [7:0] cb,
                                 input logic [7:0] cr, input logic ordy, input logic clr,
                                 output logic accepted);
        in_valid  = v;
        y_in      = y;
        cb_in     = cb;
        cr_in     = cr;
        out_ready = ordy;
        sat_clr   = clr;
        @(negedge clk);
        accepted = v && in_ready;
        @(posedge clk);
        if (accepted) expQ.push_back(goldenModel(y, cb, cr));
        #1;
    endtask

    task automatic idleCycles(input int n, input logic ordy);
        logic dummy;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, ordy, 1'b0, dummy);
    endtask

    task automatic waitEdge;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pops, stall hold, in_ready tracking and a
    // reference model of the saturation counter.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            expCount  = 0;
            prevStall = 1'b0;
            seenReset = 1'b1;
        end else if (seenReset) begin
            obsPix = pix_t'({r_out, g_out, b_out, sat_flag});
            checkOutput("sat_count", 32'(sat_count), 32'(expCount));
            if (checkInReady) checkOutput("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prevStall) checkOutput("stall_hold", 32'({out_valid, obsPix}), 32'({1'b1, heldPix}));
            prevStall = out_valid && !out_ready;
            heldPix   = obsPix;
            incNext   = 1'b0;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    expPix = expQ.pop_front();
                    checkOutput("pixel", 32'(obsPix), 32'(expPix));
                    incNext = expPix.sat;
                end
            end
            if (sat_clr) expCount = 0;
            else if (incNext && expCount < 65535) expCount = expCount + 1;
        end
    end

    // Hard stop if the run ever wedges.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic acc;
        int   k;
        int   tries;
        int   n;
        logic [7:0] py  [6];
        logic [7:0] pcb [6];
        logic [7:0] pcr [6];
        logic       pat [3];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        y_in = '0; cb_in = '0; cr_in = '0;

        // Reset state.
        waitEdge();
        waitEdge();
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
        checkOutput("rst_sat_flag", 32'(sat_flag), 32'd0);
        checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
        waitEdge();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        waitEdge();

        // Neutral grey with exact three-edge latency.
        applyStimulus(1'b1, 8'd128, 8'd0, 8'd0, 1'b1, 1'b0, acc);
        checkOutput("grey_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("grey_lat1", 32'(out_valid), 32'd0);
        waitEdge();
        @(negedge clk);
        checkOutput("grey_lat2", 32'(out_valid), 32'd0);
        waitEdge();
        @(negedge clk);
        checkOutput("grey_lat3", 32'(out_valid), 32'd1);
        checkOutput("grey_rgb", 32'({r_out, g_out, b_out, sat_flag}), 32'({8'd128, 8'd128, 8'd128, 1'b0}));
        waitEdge();

        // Mixed rounding, no saturation.
        applyStimulus(1'b1, 8'd100, 8'd20, 8'hE2, 1'b1, 1'b0, acc);
        idleCycles(4, 1'b1);
        @(negedge clk);
        checkOutput("mixed_sat_count", 32'(sat_count), 32'd0);
        waitEdge();

        // Clamp high, then clamp low.
        applyStimulus(1'b1, 8'd255, 8'd0, 8'd127, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 8'd0, 8'd0, 8'h80, 1'b1, 1'b0, acc);
        idleCycles(4, 1'b1);
        @(negedge clk);
        checkOutput("clamp_sat_count", 32'(sat_count), 32'd2);
        checkOutput("clamp_drained", 32'(expQ.size()), 32'd0);
        waitEdge();

        // Back-pressure with out_ready pattern 1,0,0 repeating.
        $display("[TB] back-pressure sequence");
        py  = '{8'd16, 8'd50, 8'd200, 8'd90, 8'd30, 8'd235};
        pcb = '{8'd0,  8'd10, 8'hD8,  8'd60, 8'hEC, 8'd5};
        pcr = '{8'd0,  8'hF6, 8'd30,  8'hC4, 8'd20, 8'd5};
        pat = '{1'b1, 1'b0, 1'b0};
        checkInReady = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 20) begin
                applyStimulus(1'b1, py[i], pcb[i], pcr[i], pat[k % 3], 1'b0, acc);
                k++;
                tries++;
            end
            checkOutput("bp_accept", 32'(acc), 32'd1);
        end
        idleCycles(8, 1'b1);
        checkInReady = 1'b0;
        checkOutput("bp_drained", 32'(expQ.size()), 32'd0);

        // Counter saturation at all-ones.
        $display("[TB] counter preload");
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, acc);
        sat_clr = 1'b0;
        @(negedge clk);
        checkOutput("cnt_cleared", 32'(sat_count), 32'd0);
        waitEdge();
        for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 8'd255, 8'd0, 8'd127, 1'b1, 1'b0, acc);
        idleCycles(4, 1'b1);
        @(negedge clk);
        checkOutput("cnt_full", 32'(sat_count), 32'd65535);
        waitEdge();
        applyStimulus(1'b1, 8'd255, 8'd0, 8'd127, 1'b1, 1'b0, acc);
        idleCycles(4, 1'b1);
        @(negedge clk);
        checkOutput("cnt_hold", 32'(sat_count), 32'd65535);
        waitEdge();

        // Clear coincident with a saturating output handshake.
        applyStimulus(1'b1, 8'd255, 8'd0, 8'd127, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("clr_wait", 32'(out_valid), 32'd1);
        waitEdge();
        applyStimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, acc);
        sat_clr = 1'b0;
        @(negedge clk);
        checkOutput("clr_priority", 32'(sat_count), 32'd0);
        waitEdge();

        // One saturated pixel so the reset has a nonzero count to clear.
        applyStimulus(1'b1, 8'd0, 8'd0, 8'h80, 1'b1, 1'b0, acc);
        idleCycles(4, 1'b1);
        @(negedge clk);
        checkOutput("pre_rst_count", 32'(sat_count), 32'd1);
        waitEdge();

        // Mid-stream reset with three pixels in flight.
        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'd255, 8'd0, 8'd127, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'd77, 8'd3, 8'd4, 1'b0, 1'b0, acc);
        checkOutput("rst_fill", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        waitEdge();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_rgb", 32'({r_out, g_out, b_out, sat_flag}), 32'd0);
        checkOutput("mid_rst_count", 32'(sat_count), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        waitEdge();
        idleCycles(8, 1'b1);
        checkOutput("final_queue", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
